// File: rtl/lfsr_pkg.sv
// ============================================================================
// Module   : lfsr_pkg
// Brief    : Shared FSM type, maximal-length tap table and feedback helper
//            for the lfsr_gen pattern generator.
// Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

package lfsr_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fsm_state_t;

  localparam int unsigned C_MIN_WIDTH = 3;
  localparam int unsigned C_MAX_WIDTH = 32;

  // Masks use the shift-left form: bit i set means state[i] feeds the XOR.
  function automatic logic [31:0] lfsr_default_taps(input int unsigned width);
    logic [31:0] taps;
    case (width)
      3:       taps = 32'h0000_0006;
      4:       taps = 32'h0000_000C;
      5:       taps = 32'h0000_0014;
      6:       taps = 32'h0000_0030;
      7:       taps = 32'h0000_0060;
      8:       taps = 32'h0000_00B8;
      9:       taps = 32'h0000_0110;
      10:      taps = 32'h0000_0240;
      11:      taps = 32'h0000_0500;
      12:      taps = 32'h0000_0829;
      13:      taps = 32'h0000_100D;
      14:      taps = 32'h0000_2015;
      15:      taps = 32'h0000_6000;
      16:      taps = 32'h0000_D008;
      17:      taps = 32'h0001_2000;
      18:      taps = 32'h0002_0400;
      19:      taps = 32'h0004_0023;
      20:      taps = 32'h0009_0000;
      21:      taps = 32'h0014_0000;
      22:      taps = 32'h0030_0000;
      23:      taps = 32'h0042_0000;
      24:      taps = 32'h00E1_0000;
      25:      taps = 32'h0120_0000;
      26:      taps = 32'h0200_0023;
      27:      taps = 32'h0400_0013;
      28:      taps = 32'h0900_0000;
      29:      taps = 32'h1400_0000;
      30:      taps = 32'h2000_0029;
      31:      taps = 32'h4800_0000;
      32:      taps = 32'h8020_0003;
      default: taps = 32'h0000_0000;
    endcase
    return taps;
  endfunction

  function automatic logic lfsr_feedback(input logic [31:0] state,
                                         input logic [31:0] mask);
    return ^(state & mask);
  endfunction

endpackage : lfsr_pkg

`default_nettype wire

// File: rtl/lfsr_gen_if.sv
// ============================================================================
// Module   : lfsr_gen_if
// Brief    : Control, seed and valid/ready output bundle of lfsr_gen.
// Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

interface lfsr_gen_if #(
  parameter int WIDTH = 10
);

  logic             start_i;
  logic             stop_i;
  logic             load_i;
  logic [WIDTH-1:0] seed_i;
  logic             ready_i;
  logic [WIDTH-1:0] data_o;
  logic             valid_o;
  logic             wrap_o;
  logic [31:0]      period_o;

  modport master (
    input  start_i, stop_i, load_i, seed_i, ready_i,
    output data_o, valid_o, wrap_o, period_o
  );

  modport slave (
    output start_i, stop_i, load_i, seed_i, ready_i,
    input  data_o, valid_o, wrap_o, period_o
  );

endinterface : lfsr_gen_if

`default_nettype wire

// File: rtl/lfsr_gen_core.sv
// ============================================================================
// Module   : lfsr_core
// Brief    : Fibonacci LFSR state register with seed load and advance enable.
// Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 10,
  parameter logic [WIDTH-1:0] TAPS  = 10'h240,
  parameter logic [WIDTH-1:0] SEED  = 10'h001
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             load_i,
  input  wire logic [WIDTH-1:0] seed_i,
  input  wire logic             adv_i,
  output logic      [WIDTH-1:0] state_o,
  output logic      [WIDTH-1:0] next_o,
  output logic      [WIDTH-1:0] seed_eff_o
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic             w_fb;

  assign w_fb       = lfsr_feedback(32'(state_q), 32'(TAPS));
  assign next_o     = {state_q[WIDTH-2:0], w_fb};
  // An all-zero seed would lock the register, so it is replaced by 1.
  assign seed_eff_o = (seed_i == '0) ? WIDTH'(1) : seed_i;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = seed_eff_o;
    end else if (adv_i) begin
      state_d = next_o;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule : lfsr_core

`default_nettype wire

// File: rtl/lfsr_gen.sv
// ============================================================================
// Module   : lfsr_gen
// Brief    : PRBS generator with start/stop FSM, valid/ready output and wrap
//            detection. Macro LFSR_PERIOD_CNT_EN adds the period counter.
// Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 10,
  parameter logic [WIDTH-1:0] TAPS  = 10'h240,
  parameter logic [WIDTH-1:0] SEED  = 10'h001
) (
  input wire logic   clk,
  input wire logic   rst,
  lfsr_gen_if.master bus
);

  fsm_state_t       state_q;
  fsm_state_t       state_d;
  logic [WIDTH-1:0] ref_q;
  logic             wrap_q;
  logic [WIDTH-1:0] w_state;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_seed_eff;
  logic             w_valid;
  logic             w_adv;
  logic             w_hit_ref;

  assign w_valid   = (state_q == ST_RUN);
  // A load discards any same-cycle transfer.
  assign w_adv     = w_valid & bus.ready_i & ~bus.load_i;
  assign w_hit_ref = (w_next == ref_q);

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .load_i     (bus.load_i),
    .seed_i     (bus.seed_i),
    .adv_i      (w_adv),
    .state_o    (w_state),
    .next_o     (w_next),
    .seed_eff_o (w_seed_eff)
  );

  always_comb begin
    state_d = state_q;
    if (!bus.load_i) begin
      case (state_q)
        ST_IDLE: if (bus.start_i && !bus.stop_i) state_d = ST_RUN;
        ST_RUN:  if (bus.stop_i)                 state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ref_q   <= SEED;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wrap_q  <= w_adv & w_hit_ref;
      if (bus.load_i) begin
        ref_q <= w_seed_eff;
      end
    end
  end

  assign bus.data_o  = w_state;
  assign bus.valid_o = w_valid;
  assign bus.wrap_o  = wrap_q;

`ifdef LFSR_PERIOD_CNT_EN
  logic [31:0] cnt_q;
  logic [31:0] cnt_d;
  logic [31:0] period_q;
  logic [31:0] period_d;
  logic [31:0] w_cnt_inc;

  assign w_cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;

  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    if (bus.load_i) begin
      cnt_d    = '0;
      period_d = '0;
    end else if (w_adv) begin
      if (w_hit_ref) begin
        period_d = w_cnt_inc;
        cnt_d    = '0;
      end else begin
        cnt_d = w_cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      period_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
    end
  end

  assign bus.period_o = period_q;
`else
  assign bus.period_o = 32'd0;
`endif

endmodule : lfsr_gen

`default_nettype wire

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
- Parametrised Fibonacci LFSR pattern generator. Replaces the fixed 10-bit x^10+x^7+1 generator.
- Width, tap polynomial and seed are set by parameters. Adds runtime seed load, start/stop control, a valid/ready output handshake, and wrap detection.
- Used as a PRBS source for datapath tests and lab stimulus. Sits between the clock/reset generator and any consumer that can apply backpressure.

Parameters:
- WIDTH, 10, LFSR register width; legal range 3..32.
- TAPS, 10'h240, feedback mask; bit i set means state[i] feeds the XOR. Default is x^10+x^7+1.
- SEED, 10'h001, state value after reset; must be nonzero.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset; one clock; reset is asynchronous and active-high
- start_i  input  1  pulse: enter RUN
- stop_i  input  1  pulse: return to IDLE
- load_i  input  1  pulse: load seed_i into state and into the wrap reference
- seed_i  input  WIDTH  runtime seed value
- ready_i  input  1  consumer accepts data_o
- data_o  output  WIDTH  current LFSR state
- valid_o  output  1  data_o is valid
- wrap_o  output  1  one-cycle pulse: sequence returned to its reference seed
- period_o  output  32  transfers counted between the last two wraps (optional feature only)

Behaviour:
- Reset values:
  - state and reference = SEED; data_o = SEED
  - valid_o = 0, wrap_o = 0, period_o = 0
  - FSM in IDLE
- Next-state function:
  - fb = ^(state & TAPS)
  - next = {state[WIDTH-2:0], fb}
  - data_o is the state register directly (no extra output stage).
- FSM states:
  - IDLE: valid_o=0, state frozen.
    - start_i -> RUN next cycle; valid_o=1 in that cycle.
  - RUN: valid_o=1.
    - A transfer occurs when valid_o && ready_i; state <= next.
    - ready_i=0 holds data_o stable (backpressure).
    - stop_i -> IDLE next cycle. A transfer in the same cycle as stop_i still completes.
- Load:
  - load_i in any state: state <= seed_i and reference <= seed_i. FSM state is unchanged.
  - If seed_i == 0, the value loaded is 1, to avoid all-zero lockup.
  - load_i wins over a same-cycle transfer: that transfer is discarded and the state does not advance.
- Priority when control pulses coincide: load_i, then stop_i, then start_i.
  - start_i and stop_i together in IDLE: remain IDLE.
  - start_i in RUN is ignored.
- Wrap:
  - wrap_o=1 for exactly one cycle, on the cycle after a transfer whose next value equals the reference.
  - For a maximal-length polynomial, this happens once every 2^WIDTH-1 transfers.
  - A non-maximal TAPS mask simply gives a shorter period; no error is raised.
- Reset mid-operation: immediate return to reset values. Any transfer in progress is lost.

Optional Feature:
- Macro: LFSR_PERIOD_CNT_EN
- Defined:
  - A 32-bit transfer counter increments on each transfer.
  - On wrap, period_o <= count+1 and the counter clears.
  - load_i and rst clear both the counter and period_o.
  - The counter saturates at 2^32-1.
- Undefined:
  - No counter logic is generated; period_o is tied to 0.
  - All other behaviour is identical.

Decomposition:
- Shared package lfsr_pkg:
  - FSM state typedef (IDLE, RUN)
  - default tap constants for widths 3..32 (maximal-length masks)
  - a feedback function taking state and mask
- Sub-module lfsr_core: state register, feedback, load, advance-enable.
  - Has no knowledge of the handshake.
  - lfsr_gen adds the FSM, handshake, wrap compare and the optional counter.

Test Plan:
- Release reset, start_i pulse, ready_i=1 constantly -> data_o sequence 1,2,4,8,16,32,64,129,...; valid_o rises one cycle after start_i.
- Continue to the full period with LFSR_PERIOD_CNT_EN defined -> wrap_o pulses after transfer 1023 with data_o back to 1; period_o=1023; second wrap 1023 transfers later.
- In RUN at data_o=8, drop ready_i for 5 cycles -> data_o holds 8 and valid_o stays 1; next value 16 appears one cycle after ready_i returns.
- load_i with seed_i=0 during a transfer -> state=1, that transfer is discarded; load_i with seed_i=10'h155 -> data_o=10'h155, and wrap_o later fires on return to 10'h155.
- stop_i and start_i in the same cycle while IDLE -> remains IDLE with valid_o=0; stop_i in RUN -> valid_o=0 next cycle and state frozen.
- Assert rst mid-RUN, asynchronously between clock edges -> immediately data_o=SEED, valid_o=0, wrap_o=0, period_o=0.
